// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using the reverse double-dabble algorithm.
// It performs one right shift per clock and flags overflow and invalid digits.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  ovf,
  output logic                  err
);

  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DW-1:0]      r_dig;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin_out;
  logic               r_ovf;
  logic               r_err;

  logic               w_accept;
  logic               w_bad;
  logic               w_last;
  logic [DW-1:0]      w_dig_adj;
  logic [BIN_W-1:0]   w_bin_sh;

  function automatic logic f_bad_digit(input logic [DW-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // After the shift, any digit holding 8 or more carried a "ten" down from
  // the digit above; subtracting 3 turns that 16-based weight back into 10.
  function automatic logic [DW-1:0] f_adjust(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd8) r[4*i +: 4] = d[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_bad     = f_bad_digit(bcd_in);
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));
  assign w_bin_sh  = {r_dig[0], r_bin[BIN_W-1:1]};
  assign w_dig_adj = f_adjust(r_dig >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_bad ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dig <= bcd_in;
            r_bin <= '0;
            r_cnt <= '0;
            if (w_bad) begin
              r_bin_out <= '0;
              r_ovf     <= 1'b0;
              r_err     <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_dig <= w_dig_adj;
          r_bin <= w_bin_sh;
          r_cnt <= r_cnt + CNT_W'(1);
          // Anything left in the digit field after the final shift did not fit.
          if (w_last) begin
            r_bin_out <= w_bin_sh;
            r_ovf     <= |w_dig_adj;
            r_err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign ovf     = r_ovf;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed table, stall/reset
// sequences and random operands checked against a decimal arithmetic model.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 8;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic                out_valid;
  logic                out_ready;
  logic [BIN_W-1:0]    bin_out;
  logic                ovf;
  logic                err;

  int n_cmp;
  int n_bad;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [7:0]  bin;
    logic        ovf;
    logic        err;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal value of the digits, reduced to BIN_W bits.
  task automatic model(input logic [4*DIGITS-1:0] bcd, output logic [BIN_W-1:0] b,
                       output logic o, output logic e);
    int v;
    int d;
    v = 0;
    e = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) begin
      b = '0;
      o = 1'b0;
    end else begin
      b = v[BIN_W-1:0];
      o = (v > (2**BIN_W - 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, count edges from the accept edge (inclusive) until
  // out_valid, capture the result and complete the handshake.
  task automatic run(input logic [11:0] bcd, output logic [7:0] b, output logic o,
                     output logic e, output int lat);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    bcd_in   = bcd;
    tick();
    in_valid = 1'b0;
    bcd_in   = 12'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    b = bin_out;
    o = ovf;
    e = err;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[7];
    logic [7:0]  b;
    logic        o;
    logic        e;
    int          lat;
    logic [11:0] r;
    logic [7:0]  mb;
    logic        mo;
    logic        me;

    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;

    vecs[0] = '{12'h255, 8'hFF, 1'b0, 1'b0, 9};
    vecs[1] = '{12'h000, 8'h00, 1'b0, 1'b0, 9};
    vecs[2] = '{12'h010, 8'h0A, 1'b0, 1'b0, 9};
    vecs[3] = '{12'h128, 8'h80, 1'b0, 1'b0, 9};
    vecs[4] = '{12'h256, 8'h00, 1'b1, 1'b0, 9};
    vecs[5] = '{12'h999, 8'hE7, 1'b1, 1'b0, 9};
    vecs[6] = '{12'h0A5, 8'h00, 1'b0, 1'b1, 1};

    repeat (3) tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin_out",   {24'd0, bin_out},   32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run(vecs[i].bcd, b, o, e, lat);
      chk($sformatf("vec%0d_bin", i), {24'd0, b}, {24'd0, vecs[i].bin});
      chk($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_lat", i), 32'(lat),   32'(vecs[i].lat));
    end

    // Hold the result for 5 cycles while pulsing in_valid; nothing may move.
    in_valid = 1'b1;
    bcd_in   = 12'h123;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("stall_lat", 32'(lat), 32'd9);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      bcd_in   = 12'h777;
      tick();
      chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_ready", c), {31'd0, in_ready},  32'd0);
      chk($sformatf("stall%0d_bin", c),   {24'd0, bin_out},   32'h7B);
      chk($sformatf("stall%0d_flags", c), {30'd0, ovf, err},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, in_ready},  32'd1);

    // Asynchronous reset in the middle of a conversion.
    in_valid = 1'b1;
    bcd_in   = 12'h200;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    run(12'h042, b, o, e, lat);
    chk("after_rst_bin", {24'd0, b}, 32'h2A);
    chk("after_rst_lat", 32'(lat),   32'd9);
    chk("after_rst_flags", {30'd0, o, e}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        r[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      end
      model(r, mb, mo, me);
      run(r, b, o, e, lat);
      chk($sformatf("rnd%0d_%03h_bin", i, r), {24'd0, b}, {24'd0, mb});
      chk($sformatf("rnd%0d_%03h_flags", i, r), {30'd0, o, e}, {30'd0, mo, me});
      chk($sformatf("rnd%0d_%03h_lat", i, r), 32'(lat), me ? 32'd1 : 32'(BIN_W + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
